scan_unload_reader: RTL and testbench

SCAN_UNLOAD_READER -- requirements
Module: scan_unload_reader

---
 rtl/scan_unload_reader.sv | 104 ++++++++++
 tb/tb_scan_unload_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/scan_unload_reader.sv
// Serial scan-chain unload reader: shifts CHAIN_LEN bits out of a chain, compares the
// captured response against a golden word and folds every bit into a 16-bit signature.
module scan_unload_reader #(
   parameter int CHAIN_LEN = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 scan_so,
   input  logic                 fill_bit,
   input  logic [CHAIN_LEN-1:0] expected,
   input  logic                 sig_clr,
   output logic                 scan_en,
   output logic                 scan_si,
   output logic                 busy,
   output logic [CHAIN_LEN-1:0] data,
   output logic                 data_valid,
   output logic                 pass,
   output logic [15:0]          signature
);

   localparam int CW = $clog2(CHAIN_LEN + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t               r_state;
   logic [CW-1:0]        r_cnt;
   logic [CHAIN_LEN-1:0] r_sr;
   logic [CHAIN_LEN-1:0] r_data;
   logic                 r_pass;
   logic                 r_scan_en;
   logic                 r_busy;
   logic                 r_data_valid;
   logic [15:0]          r_sig;

   logic [CHAIN_LEN-1:0] w_sr_next;
   logic                 w_fb;
   logic [15:0]          w_sig_next;

   // First bit received migrates to the MSB after CHAIN_LEN shifts.
   assign w_sr_next  = {r_sr[CHAIN_LEN-2:0], scan_so};
   assign w_fb       = r_sig[15] ^ scan_so;
   assign w_sig_next = {r_sig[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_sr         <= '0;
         r_data       <= '0;
         r_pass       <= 1'b0;
         r_scan_en    <= 1'b0;
         r_busy       <= 1'b0;
         r_data_valid <= 1'b0;
         r_sig        <= '0;
      end else begin
         r_data_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state   <= S_SHIFT;
                  r_cnt     <= CW'(CHAIN_LEN);
                  r_scan_en <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end
            S_SHIFT: begin
               r_sr <= w_sr_next;
               if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
               // Last shift edge: capture the completed word, including this edge's bit.
               if (r_cnt == CW'(1)) begin
                  r_state      <= S_DONE;
                  r_scan_en    <= 1'b0;
                  r_data       <= w_sr_next;
                  r_pass       <= (w_sr_next == expected);
                  r_data_valid <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state   <= S_IDLE;
               r_scan_en <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase

         if (sig_clr)                 r_sig <= '0;
         else if (r_state == S_SHIFT) r_sig <= w_sig_next;
      end
   end

   assign scan_en    = r_scan_en;
   assign scan_si    = r_scan_en & fill_bit;
   assign busy       = r_busy;
   assign data       = r_data;
   assign data_valid = r_data_valid;
   assign pass       = r_pass;
   assign signature  = r_sig;

endmodule

// File: tb/tb_scan_unload_reader.sv
// Directed bench for scan_unload_reader (CHAIN_LEN=8) with a response scoreboard
// and a reference signature model.
module tb_scan_unload_reader;

   logic        clk = 1'b0;
   logic        rst, start, scan_so, fill_bit, sig_clr;
   logic [7:0]  expected;
   logic        scan_en, scan_si, busy, data_valid, pass;
   logic [7:0]  data;
   logic [15:0] signature;

   scan_unload_reader #(.CHAIN_LEN(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .scan_so    (scan_so),
      .fill_bit   (fill_bit),
      .expected   (expected),
      .sig_clr    (sig_clr),
      .scan_en    (scan_en),
      .scan_si    (scan_si),
      .busy       (busy),
      .data       (data),
      .data_valid (data_valid),
      .pass       (pass),
      .signature  (signature)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic       pass;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          n_dv = 0;
   logic [15:0] sig_m;

   function automatic logic [15:0] lfsr(input logic [15:0] s, input logic b);
      logic fb;
      fb = s[15] ^ b;
      return (s << 1) ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Response monitor: every data_valid pulse must match the oldest scoreboard entry.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst === 1'b0 && data_valid === 1'b1) begin
         n_dv++;
         check("dv_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("data", 32'(data), 32'(e.data));
            check("pass", 32'(pass), 32'(e.pass));
         end
      end
   end

   task automatic do_unload(input logic [7:0] bits, input logic [7:0] exp_word,
                            input int glitch_at, input bit clr_first);
      int en_cnt;
      en_cnt   = 0;
      expected = exp_word;
      start    = 1'b1;
      sb.push_back(exp_t'{data: bits, pass: (bits == exp_word)});
      step();
      start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         fill_bit = k[0];
         scan_so  = bits[8-k];
         start    = (k == glitch_at);
         sig_clr  = (clr_first && k == 1);
         #1;
         check("scan_en_shift", 32'(scan_en), 32'd1);
         check("busy_shift", 32'(busy), 32'd1);
         check("scan_si_shift", 32'(scan_si), 32'(fill_bit));
         check("dv_shift", 32'(data_valid), 32'd0);
         en_cnt += int'(scan_en);
         sig_m = sig_clr ? 16'h0000 : lfsr(sig_m, scan_so);
         step();
         start   = 1'b0;
         sig_clr = 1'b0;
         check("sig_step", 32'(signature), 32'(sig_m));
      end
      fill_bit = 1'b1;
      #1;
      check("dv_done", 32'(data_valid), 32'd1);
      check("scan_en_done", 32'(scan_en), 32'd0);
      check("busy_done", 32'(busy), 32'd1);
      check("scan_si_done", 32'(scan_si), 32'd0);
      step();
      check("dv_after", 32'(data_valid), 32'd0);
      check("busy_after", 32'(busy), 32'd0);
      check("scan_en_after", 32'(scan_en), 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);
      step();
      check("idle_no_restart", 32'(busy), 32'd0);
      check("scan_en_idle", 32'(scan_en), 32'd0);
      check("en_count", 32'(en_cnt), 32'd8);
   endtask

   initial begin
      int dv_before;
      rst      = 1'b1;
      start    = 1'b1;
      sig_clr  = 1'b1;
      scan_so  = 1'b0;
      fill_bit = 1'b1;
      expected = 8'h00;
      sig_m    = 16'h0000;

      // Reset wins over start and sig_clr.
      step();
      step();
      start   = 1'b0;
      sig_clr = 1'b0;
      #1;
      check("rst_scan_en", 32'(scan_en), 32'd0);
      check("rst_scan_si", 32'(scan_si), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_dv", 32'(data_valid), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      check("rst_sig", 32'(signature), 32'h0000);

      // Matching unload, started in the first cycle after reset.
      rst = 1'b0;
      do_unload(8'hB2, 8'hB2, 0, 1'b0);

      // Mismatch against golden.
      do_unload(8'hB2, 8'hB3, 0, 1'b0);

      // start pulsed mid-shift is ignored.
      do_unload(8'hB2, 8'hB2, 4, 1'b0);

      // Abort with reset in SHIFT cycle 5.
      expected = 8'h00;
      start    = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         scan_so = 1'b1;
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_scan_en", 32'(scan_en), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_data", 32'(data), 32'd0);
      check("abort_pass", 32'(pass), 32'd0);
      check("abort_sig", 32'(signature), 32'd0);
      sig_m     = 16'h0000;
      dv_before = n_dv;
      step();
      step();
      check("abort_no_dv", 32'(n_dv), 32'(dv_before));
      do_unload(8'h5A, 8'h5A, 0, 1'b0);

      // sig_clr in IDLE clears only the signature.
      sig_clr = 1'b1;
      step();
      sig_clr = 1'b0;
      sig_m   = 16'h0000;
      check("clr_sig", 32'(signature), 32'd0);
      check("clr_data_kept", 32'(data), 32'h5A);
      check("clr_pass_kept", 32'(pass), 32'd1);
      check("clr_busy", 32'(busy), 32'd0);

      // All-ones unload from a zero signature.
      do_unload(8'hFF, 8'hFF, 0, 1'b0);
      check("sig_all_ones", 32'(signature), 32'h1EF0);

      // sig_clr coincident with the first shift edge wins.
      do_unload(8'hB2, 8'hB2, 0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
